// File: rtl/end_fade_ctrl.sv
// end_fade_ctrl: game-over screen fade-in / hold / fade-out sequencer.
// Optional palette rotation during HOLD when END_PAL_CYCLE_EN is defined.
module end_fade_ctrl #(
  parameter int STEP_FRAMES = 4,
  parameter int HOLD_FRAMES = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       skip,
  input  logic       frame_tick,
  input  logic       de,
  input  logic [3:0] index_in,
  output logic [3:0] pal_index,
  input  logic [3:0] pal_r,
  input  logic [3:0] pal_g,
  input  logic [3:0] pal_b,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       busy,
  output logic       done
);

  localparam int MAXF =
    (STEP_FRAMES > HOLD_FRAMES) ?
    STEP_FRAMES : HOLD_FRAMES;
  localparam int CW = $clog2(MAXF + 1);

  localparam logic [CW-1:0] STEP_LAST =
    CW'(STEP_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FADE_IN,
    S_HOLD,
    S_FADE_OUT
  } state_t;

  state_t        r_state;
  logic [4:0]    r_level;
  logic [CW-1:0] r_fcnt;
  logic          r_done;
  logic [3:0]    r_red;
  logic [3:0]    r_green;
  logic [3:0]    r_blue;

  // A tick only counts when skip is absent.
  logic w_tick;
  assign w_tick = frame_tick & ~skip;

  logic w_step_end;
  assign w_step_end = (r_fcnt == STEP_LAST);

  // Sequencer: state, fade level and frame counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_level <= 5'd0;
      r_fcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FADE_IN;
            r_level <= 5'd0;
            r_fcnt  <= '0;
          end
        end
        S_FADE_IN: begin
          if (skip) begin
            r_state <= S_HOLD;
            r_level <= 5'd16;
            r_fcnt  <= '0;
          end else if (w_tick) begin
            if (w_step_end) begin
              r_fcnt  <= '0;
              r_level <= r_level + 5'd1;
              if (r_level == 5'd15)
                r_state <= S_HOLD;
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (skip) begin
            r_state <= S_FADE_OUT;
            r_fcnt  <= '0;
          end else if (w_tick) begin
            if (r_fcnt == HOLD_LAST) begin
              r_state <= S_FADE_OUT;
              r_fcnt  <= '0;
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
        end
        S_FADE_OUT: begin
          if (w_tick) begin
            if (w_step_end) begin
              r_fcnt  <= '0;
              r_level <= r_level - 5'd1;
              if (r_level == 5'd1) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef END_PAL_CYCLE_EN
  logic [3:0]    r_rot;
  logic [CW-1:0] r_rcnt;

  // Rotation offset: steps every STEP_FRAMES ticks in HOLD only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rot  <= 4'd0;
      r_rcnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rot  <= 4'd0;
            r_rcnt <= '0;
          end
        end
        S_FADE_IN: begin
          r_rcnt <= '0;
        end
        S_HOLD: begin
          if (w_tick) begin
            if (r_rcnt == STEP_LAST) begin
              r_rcnt <= '0;
              r_rot  <= (r_rot == 4'd14) ?
                        4'd0 : r_rot + 4'd1;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        S_FADE_OUT: begin
          r_rcnt <= '0;
        end
      endcase
    end
  end

  // Index 0 is the black background and is never rotated.
  logic [4:0] w_sum;
  logic [4:0] w_wrap;
  assign w_sum  = {1'b0, index_in} - 5'd1
                + {1'b0, r_rot};
  assign w_wrap = (w_sum >= 5'd15) ?
                  w_sum - 5'd15 : w_sum;
  assign pal_index = (index_in == 4'd0) ?
                     4'd0 : 4'(w_wrap + 5'd1);
`else
  assign pal_index = index_in;
`endif

  function automatic logic [3:0] f_scale(
    input logic [3:0] c,
    input logic [4:0] l
  );
    logic [8:0] p;
    p = {5'd0, c} * {4'd0, l};
    return 4'(p >> 4);
  endfunction

  // Pixel output: palette colour scaled by level, blanked outside de.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
    end else if (!de) begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
    end else begin
      r_red   <= f_scale(pal_r, r_level);
      r_green <= f_scale(pal_g, r_level);
      r_blue  <= f_scale(pal_b, r_level);
    end
  end

  assign red   = r_red;
  assign green = r_green;
  assign blue  = r_blue;
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;

endmodule

// File: tb/tb_end_fade_ctrl.sv
// tb_end_fade_ctrl: randomized bench for end_fade_ctrl.
// Reference model tracks phase and ticks-in-phase arithmetically.
module tb_end_fade_ctrl;

  localparam int STEP = 2;
  localparam int HOLD = 3;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic       skip;
  logic       frame_tick;
  logic       de;
  logic [3:0] index_in;
  logic [3:0] pal_index;
  logic [3:0] pal_r;
  logic [3:0] pal_g;
  logic [3:0] pal_b;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       busy;
  logic       done;

  end_fade_ctrl #(
    .STEP_FRAMES(STEP),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .start(start),
    .skip(skip),
    .frame_tick(frame_tick),
    .de(de),
    .index_in(index_in),
    .pal_index(pal_index),
    .pal_r(pal_r),
    .pal_g(pal_g),
    .pal_b(pal_b),
    .red(red),
    .green(green),
    .blue(blue),
    .busy(busy),
    .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // model: phase 0 idle, 1 fade in, 2 hold, 3 fade out
  int m_ph  = 0;
  int m_n   = 0;
  int m_rot = 0;

  logic [13:0] exp_v;
  logic [3:0]  exp_pidx;
  logic [3:0]  got_pidx;
  int          done_cnt;

  function automatic int m_level();
    case (m_ph)
      1: return m_n / STEP;
      2: return 16;
      3: return 16 - m_n / STEP;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] sc(
    input logic [3:0] c,
    input int l
  );
    return 4'((int'(c) * l) / 16);
  endfunction

  // Applies one clock of inputs and advances the model.
  task automatic clk_step(
    input logic rst, input logic st,
    input logic sk, input logic tk,
    input logic [3:0] idx,
    input logic [3:0] r, input logic [3:0] g,
    input logic [3:0] b, input logic d
  );
    int lv;
    logic dn;
    Reset = rst; start = st; skip = sk;
    frame_tick = tk; index_in = idx;
    pal_r = r; pal_g = g; pal_b = b; de = d;
    #1;
    got_pidx = pal_index;
`ifdef END_PAL_CYCLE_EN
    exp_pidx = (idx == 4'd0) ? 4'd0 :
      4'(((int'(idx) - 1 + m_rot) % 15) + 1);
`else
    exp_pidx = idx;
`endif
    lv = m_level();
    dn = 1'b0;
    @(posedge Clk);
    if (rst) begin
      m_ph = 0; m_n = 0; m_rot = 0;
    end else begin
      case (m_ph)
        0: if (st) begin
          m_ph = 1; m_n = 0; m_rot = 0;
        end
        1: if (sk) begin
          m_ph = 2; m_n = 0;
        end else if (tk) begin
          m_n++;
          if (m_n / STEP >= 16) begin
            m_ph = 2; m_n = 0;
          end
        end
        2: if (sk) begin
          m_ph = 3; m_n = 0;
        end else if (tk) begin
          m_n++;
          m_rot = (m_n / STEP) % 15;
          if (m_n == HOLD) begin
            m_ph = 3; m_n = 0;
          end
        end
        3: if (!sk && tk) begin
          m_n++;
          if (16 - m_n / STEP == 0) begin
            m_ph = 0; m_n = 0; dn = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (rst || !d)
      exp_v = {12'h000, 1'b0, 1'b0};
    else
      exp_v = {sc(r, lv), sc(g, lv), sc(b, lv),
               1'b0, 1'b0};
    exp_v[1] = (m_ph != 0);
    exp_v[0] = dn;
    #1;
  endtask

  task automatic rnd_step(
    input logic rst, input logic st,
    input logic sk, input logic tk
  );
    clk_step(rst, st, sk, tk,
      4'($urandom), 4'($urandom), 4'($urandom),
      4'($urandom), ($urandom_range(0, 7) != 0));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rnd_step(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({red, green, blue, busy, done} !== 14'd0) begin
        errors++;
        $display("FAIL reset got=%h exp=0",
          {red, green, blue, busy, done});
      end
    end
  endtask

  task automatic test_full_seq();
    rnd_step(1'b0, 1'b1, 1'b0, 1'b1);
    done_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      rnd_step(1'b0, 1'b0, 1'b0,
        ($urandom_range(0, 3) != 0));
      if (done === 1'b1) done_cnt++;
      checks++;
      if ({red, green, blue, busy, done} !== exp_v ||
          got_pidx !== exp_pidx) begin
        errors++;
        $display("FAIL full_seq i=%0d got=%h/%h exp=%h/%h",
          i, {red, green, blue, busy, done}, got_pidx,
          exp_v, exp_pidx);
      end
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_once got=%0d busy=%b exp=1 busy=0",
        done_cnt, busy);
    end
  endtask

  task automatic test_scale();
    rnd_step(1'b1, 1'b0, 1'b0, 1'b0);
    rnd_step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      rnd_step(1'b0, 1'b0, 1'b0, 1'b1);
    clk_step(1'b0, 1'b0, 1'b0, 1'b0, 4'd3,
      4'hF, 4'hE, 4'h5, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'h772 ||
        {red, green, blue, busy, done} !== exp_v) begin
      errors++;
      $display("FAIL scale_l8 got=%h exp=772",
        {red, green, blue});
    end
    clk_step(1'b0, 1'b0, 1'b0, 1'b0, 4'd3,
      4'hF, 4'hE, 4'h5, 1'b0);
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL scale_de0 got=%h exp=000",
        {red, green, blue});
    end
  endtask

  task automatic test_skip_fadein();
    rnd_step(1'b1, 1'b0, 1'b0, 1'b0);
    rnd_step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      rnd_step(1'b0, 1'b0, 1'b0, 1'b1);
    clk_step(1'b0, 1'b0, 1'b1, 1'b0, 4'd1,
      4'hF, 4'hF, 4'hF, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'h444) begin
      errors++;
      $display("FAIL skip_l5 got=%h exp=444",
        {red, green, blue});
    end
    clk_step(1'b0, 1'b0, 1'b0, 1'b0, 4'd1,
      4'hF, 4'h6, 4'hA, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'hF6A ||
        busy !== 1'b1) begin
      errors++;
      $display("FAIL skip_hold got=%h busy=%b exp=f6a busy=1",
        {red, green, blue}, busy);
    end
  endtask

  task automatic test_hold_skip_tick();
    clk_step(1'b0, 1'b0, 1'b1, 1'b1, 4'd1,
      4'hF, 4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      clk_step(1'b0, 1'b0, 1'b0, (i < 2), 4'd1,
        4'hF, 4'hF, 4'hF, 1'b1);
      checks++;
      if (red !== ((i < 2) ? 4'hF : 4'hE) ||
          {red, green, blue, busy, done} !== exp_v) begin
        errors++;
        $display("FAIL hold_skip_tick i=%0d got=%h exp=%h",
          i, red, (i < 2) ? 4'hF : 4'hE);
      end
    end
  endtask

  task automatic test_reset_mid();
    rnd_step(1'b1, 1'b0, 1'b0, 1'b0);
    rnd_step(1'b0, 1'b1, 1'b0, 1'b0);
    rnd_step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++)
      rnd_step(1'b0, 1'b0, 1'b0, 1'b1);
    clk_step(1'b0, 1'b0, 1'b0, 1'b0, 4'd2,
      4'hF, 4'hF, 4'hF, 1'b1);
    checks++;
    if (red !== 4'h8 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_l9 got=%h busy=%b exp=8 busy=1",
        red, busy);
    end
    clk_step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2,
      4'hF, 4'hF, 4'hF, 1'b1);
    checks++;
    if ({red, green, blue, busy, done} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=0",
        {red, green, blue, busy, done});
    end
    for (int i = 0; i < 6; i++) begin
      clk_step(1'b0, 1'b0, 1'b0, 1'b1, 4'd2,
        4'hF, 4'hF, 4'hF, 1'b1);
      checks++;
      if ({red, green, blue, busy, done} !== 14'd0) begin
        errors++;
        $display("FAIL idle_after_reset i=%0d got=%h exp=0",
          i, {red, green, blue, busy, done});
      end
    end
    rnd_step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      rnd_step(1'b0, 1'b0, 1'b0, 1'b1);
    clk_step(1'b0, 1'b0, 1'b0, 1'b0, 4'd2,
      4'hF, 4'hF, 4'hF, 1'b1);
    checks++;
    if (red !== 4'h1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_l2 got=%h busy=%b exp=1 busy=1",
        red, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rnd_step(($urandom_range(0, 299) == 0),
        ($urandom_range(0, 9) == 0),
        ($urandom_range(0, 24) == 0),
        ($urandom_range(0, 2) == 0));
      checks++;
      if ({red, green, blue, busy, done} !== exp_v ||
          got_pidx !== exp_pidx) begin
        errors++;
        $display("FAIL random i=%0d got=%h/%h exp=%h/%h",
          i, {red, green, blue, busy, done}, got_pidx,
          exp_v, exp_pidx);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; skip = 1'b0;
    frame_tick = 1'b0; de = 1'b0; index_in = 4'd0;
    pal_r = 4'd0; pal_g = 4'd0; pal_b = 4'd0;
    test_reset();
    test_full_seq();
    test_scale();
    test_skip_fadein();
    test_hold_skip_tick();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
